// File: rtl/csa_mult_seq_if.sv
// Operand/result bus for csa_mult_seq.
//   start   : request, sampled only while the multiplier is idle
//   a, b    : WIDTH-bit unsigned operands, captured on the accept edge
//   busy    : operation in flight
//   done    : one-cycle pulse; product valid from this cycle on
//   product : 2*WIDTH-bit result, held until the next done
// master drives requests, slave is the multiplier.
interface csa_mult_seq_if #(parameter int WIDTH = 32);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/csa_mult_seq.sv
// Sequential unsigned shift-and-add multiplier with a carry-save accumulator.
// One partial product is folded into a redundant (sum, carry) pair per cycle
// through a row of full adders; one carry-propagate add resolves the result.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (dominates start)
//   bus  : csa_mult_seq_if.slave (start/a/b in, busy/done/product out)
// Optional build macro:
//   CSA_SEQ_EARLY_EXIT_EN - leave the accumulate phase once no multiplier
//   ones remain; latency becomes msb_index(b)+2 instead of WIDTH+1.

// One bit of the carry-save row.
module csa_fa (
  input  logic i_x,
  input  logic i_y,
  input  logic i_z,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y ^ i_z;
  assign o_c = (i_x & i_y) | (i_x & i_z) | (i_y & i_z);
endmodule

module csa_mult_seq #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  csa_mult_seq_if.slave bus
);
  localparam int             W2   = 2 * WIDTH;
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESOLVE} state_t;

  state_t           r_state;
  state_t           w_nxt_state;
  logic [W2-1:0]    r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [W2-1:0]    r_sum;
  logic [W2-1:0]    r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [W2-1:0]    r_product;

  logic [W2-1:0]    w_pp;
  logic [W2-1:0]    w_sum;
  logic [W2-1:0]    w_maj;
  logic [W2-1:0]    w_carry;
  logic             w_last;

  assign w_pp = r_b_sh[0] ? r_a_sh : '0;

  // Carry-save row: 3:2 compression of (sum, carry, pp) per bit.
  for (genvar i = 0; i < W2; i++) begin : g_fa
    csa_fa u_fa (
      .i_x (r_sum[i]),
      .i_y (r_carry[i]),
      .i_z (w_pp[i]),
      .o_s (w_sum[i]),
      .o_c (w_maj[i])
    );
  end

  // Carries move one place up; the bit leaving the top is dropped since
  // the true product always fits in 2*WIDTH bits.
  assign w_carry = {w_maj[W2-2:0], 1'b0};

`ifdef CSA_SEQ_EARLY_EXIT_EN
  // Bit 0 is consumed this edge, so stop once nothing above it is set.
  assign w_last = (r_cnt == LAST) || (r_b_sh[WIDTH-1:1] == '0);
`else
  assign w_last = (r_cnt == LAST);
`endif

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_nxt_state = S_ACCUM;
      S_ACCUM:   if (w_last)    w_nxt_state = S_RESOLVE;
      S_RESOLVE: w_nxt_state = S_IDLE;
      default:   w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_sum     <= '0;
      r_carry   <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sh  <= {{WIDTH{1'b0}}, bus.a};
            r_b_sh  <= bus.b;
            r_sum   <= '0;
            r_carry <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_ACCUM: begin
          r_sum   <= w_sum;
          r_carry <= w_carry;
          r_a_sh  <= {r_a_sh[W2-2:0], 1'b0};
          r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_cnt   <= r_cnt + CW'(1);
        end
        S_RESOLVE: begin
          r_product <= r_sum + r_carry;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;
endmodule
